// File: rtl/trig_conditioner_pkg.sv
// Shared types and default parameter values for the trig_conditioner trigger front end.
package trig_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned PULSE_CYCLES_DEF    = 100;
  localparam int unsigned HOLDOFF_CYCLES_DEF  = 200;
  localparam int unsigned CNT_W_DEF           = 8;

endpackage

// File: rtl/trig_conditioner_if.sv
// Trigger request / conditioned pulse bundle between a requester and trig_conditioner.
// miss_cnt exists only when TRIG_CONDITIONER_MISS_CNT_EN is defined.
interface trig_conditioner_if
  import trig_cond_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             trig_in;
    logic             arm;
    logic             trig;
    logic             busy;
    logic [CNT_W-1:0] trig_cnt;
`ifdef TRIG_CONDITIONER_MISS_CNT_EN
    logic [CNT_W-1:0] miss_cnt;

    modport master (output trig_in, arm, input trig, busy, trig_cnt, miss_cnt);
    modport slave  (input trig_in, arm, output trig, busy, trig_cnt, miss_cnt);
`else
    modport master (output trig_in, arm, input trig, busy, trig_cnt);
    modport slave  (input trig_in, arm, output trig, busy, trig_cnt);
`endif
endinterface

// File: rtl/trig_conditioner_debounce.sv
// Synchroniser plus debouncer: db_level follows trig_in only after it has held a
// new level for DEBOUNCE_CYCLES consecutive synchronised samples.
module trig_debounce
  import trig_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_in,
    output logic db_level
);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DBW-1:0]         dbc;
    logic                   s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any sample matching the accepted level restarts the qualification run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            dbc      <= '0;
        end else if (s == db_level) begin
            dbc <= '0;
        end else if (dbc == DB_LAST) begin
            db_level <= s;
            dbc      <= '0;
        end else begin
            dbc <= dbc + DBW'(1);
        end
    end

endmodule

// File: rtl/trig_conditioner.sv
// Trigger conditioner: debounced rising edge -> fixed-width trig pulse -> holdoff.
// Optional discarded-rise counter enabled by TRIG_CONDITIONER_MISS_CNT_EN.
module trig_conditioner
  import trig_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF,
    parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    trig_conditioner_if.slave  bus
);
    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);

    state_t           state_q, state_d;
    logic             db_level, db_level_q, rise, start;
    logic [PW-1:0]    pcnt;
    logic [HW-1:0]    hcnt;
    logic [CNT_W-1:0] trig_cnt_q;
    logic             trig_q, busy_q;

    trig_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_in  (bus.trig_in),
        .db_level (db_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) db_level_q <= 1'b0;
        else        db_level_q <= db_level;
    end

    assign rise = db_level & ~db_level_q;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && bus.arm) begin
                    state_d = PULSE;
                    start   = 1'b1;
                end
            end
            PULSE:   if (pcnt == '0) state_d = HOLDOFF;
            HOLDOFF: if (hcnt == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode state_d so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            pcnt       <= '0;
            hcnt       <= '0;
            trig_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= (state_d == PULSE);
            busy_q  <= (state_d != IDLE);
            if (start)                           pcnt <= PULSE_LAST;
            else if (state_q == PULSE && pcnt != '0) pcnt <= pcnt - PW'(1);
            if (state_q == PULSE && state_d == HOLDOFF) hcnt <= HOLD_LAST;
            else if (state_q == HOLDOFF && hcnt != '0)  hcnt <= hcnt - HW'(1);
            if (start) trig_cnt_q <= trig_cnt_q + CNT_W'(1);
        end
    end

    assign bus.trig     = trig_q;
    assign bus.busy     = busy_q;
    assign bus.trig_cnt = trig_cnt_q;

`ifdef TRIG_CONDITIONER_MISS_CNT_EN
    logic             miss;
    logic [CNT_W-1:0] miss_q;

    always_comb miss = rise & ((state_q != IDLE) | ~bus.arm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    miss_q <= '0;
        else if (miss) miss_q <= miss_q + CNT_W'(1);
    end

    assign bus.miss_cnt = miss_q;
`endif

endmodule

// File: doc/trig_conditioner.md
Name: trig_conditioner

Overview:
- Upstream front end for eight_bit_cnt. Conditions a raw, asynchronous trigger input and drives that counter's trig input.
- Pipeline: synchronise, then debounce, then rising-edge detect, then emit a fixed-width trig pulse, then enforce a holdoff.
- Glitches, bounce and retriggers during the holdoff never reach the counter.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the trig_in synchroniser (≥2).
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised level must persist before it is accepted (≥1).
- PULSE_CYCLES, 100, width of the trig output pulse in clk cycles (≥1).
- HOLDOFF_CYCLES, 200, dead time after the pulse; rising edges are ignored during it (≥1).
- CNT_W, 8, width of trig_cnt.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- trig_in, input, 1, raw asynchronous trigger request.
- arm, input, 1, enables new pulses; sampled only in IDLE.
- trig, output, 1, conditioned pulse to eight_bit_cnt; registered.
- busy, output, 1, high while in PULSE or HOLDOFF.
- trig_cnt, output, CNT_W, number of pulses issued; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. While rst_n=0, all flops clear immediately without a clock edge: trig=0, busy=0, trig_cnt=0, state=IDLE, debounced level=0, debounce counter=0.
- Synchroniser: trig_in passes through SYNC_STAGES flops, producing s.
- Debounce:
  - Counter dbc has width $clog2(DEBOUNCE_CYCLES+1).
  - If s equals db_level, dbc is cleared to 0.
  - Otherwise dbc increments. When dbc reaches DEBOUNCE_CYCLES-1 while s still differs, db_level takes the value of s and dbc is cleared.
  - Result: db_level changes only after DEBOUNCE_CYCLES consecutive mismatching samples.
- Edge detect: db_level_q is db_level delayed by one cycle. rise = db_level & ~db_level_q.
- FSM:
  - IDLE: if rise and arm, go to PULSE, load the pulse counter, and increment trig_cnt. Otherwise stay.
  - PULSE: trig=1 for exactly PULSE_CYCLES cycles, then go to HOLDOFF. arm and rise are ignored, so deasserting arm never truncates a pulse.
  - HOLDOFF: trig=0 for exactly HOLDOFF_CYCLES cycles, then go to IDLE. A rise during HOLDOFF, including its final cycle, is dropped, not queued.
  - trig and busy are registered decodes of the next state, so they change on the same edge as the state.
- Latency: trig_in goes high and stays clean; trig rises on clk edge SYNC_STAGES+DEBOUNCE_CYCLES+1 after the first edge that samples it high. This is edge 19 with defaults.
- Duration: busy stays high for PULSE_CYCLES+HOLDOFF_CYCLES cycles per accepted trigger.
- Falling edges of db_level never produce output.
- trig_in high across reset release: db_level starts at 0, so one trig is produced after the debounce latency, provided arm=1.
- A rise while arm=0 in IDLE is discarded. Raising arm later does not resurrect it.
- Internal counter widths are $clog2(N+1) of the respective parameter. No count overflows within its range.

Optional Feature:
- Macro: TRIG_CONDITIONER_MISS_CNT_EN.
- Defined:
  - Adds output miss_cnt[CNT_W-1:0], reset to 0.
  - Increments on every rise that is discarded: in PULSE, in HOLDOFF, or in IDLE with arm=0.
  - Wraps modulo 2^CNT_W.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package trig_cond_pkg holds:
  - state encoding typedef: IDLE=2'd0, PULSE=2'd1, HOLDOFF=2'd2;
  - default parameter constants.
- Sub-module trig_debounce: SYNC_STAGES synchroniser plus debounce counter; outputs db_level.
- The top level holds edge detect, FSM, counters and the optional miss counter.

Test Plan:
All scenarios use defaults and a 10 ns clk.
1. Reset: rst_n=0 with trig_in toggling -> trig=0, busy=0, trig_cnt=0 throughout. Assert rst_n async mid-PULSE -> trig falls within the same clock period, no edge needed.
2. Clean trigger: arm=1, trig_in high for 1000 ns -> trig high on edge 19 for exactly 100 cycles; busy high for 300 cycles; trig_cnt=1.
3. Glitch reject: trig_in pulses of 10 cycles and 15 cycles -> trig never asserts, trig_cnt=0. A 16-cycle pulse -> one trig.
4. Retrigger: second clean rise 150 cycles after the first trig (during HOLDOFF) -> no trig, trig_cnt=1; miss_cnt=1 with macro. A rise 320 cycles after the first trig -> second pulse, trig_cnt=2.
5. Arm gating: arm=0 with a clean rise -> no trig; miss_cnt=1 with macro. arm dropped 20 cycles into PULSE -> pulse still lasts 100 cycles.
6. Wrap: 256 accepted triggers -> trig_cnt returns to 0; no extra pulses.
